car_loop: RTL and testbench
===========================

CAR_LOOP -- requirements
Module: car_loop

Interface
REQ-001 Parameter ACC_WIDTH, 32, width of the carrier frequency control word (FCW) and loop integrator.
REQ-002 Parameter COR_WIDTH, 16, width of the signed I/Q correlation inputs.
REQ-003 Parameter FCW_INIT, 32'h1000_0000, nominal FCW output when the loop is idle or disabled.
REQ-004 Parameter KP_SHIFT, 8, proportional gain as a left shift.
REQ-005 Parameter KI_SHIFT, 2, integral gain as a left shift.
REQ-006 Parameter LOCK_CNT, 4, number of consecutive in-phase-dominant samples required to declare lock.
REQ-007 rx_clk  in  1  single clock; every register is on the rising edge.
REQ-008 rx_rst_n  in  1  reset, asynchronous and active-low.
REQ-009 rx_loop_en  in  1  loop closed when 1; integrator forced to 0 when 0.
REQ-010 rx_cor_valid  in  1  correlation pair valid.
REQ-011 rx_cor_i  in  COR_WIDTH  signed prompt in-phase correlation.
REQ-012 rx_cor_q  in  COR_WIDTH  signed prompt quadrature correlation.
REQ-013 tx_cor_ready  out  1  block can accept a pair.
REQ-014 tx_car_fcw  out  ACC_WIDTH  FCW to the carrier NCO.
REQ-015 tx_fcw_valid  out  1  one-cycle pulse when tx_car_fcw updates.
REQ-016 tx_lock  out  1  carrier lock indicator.

Function
REQ-017 A pair SHALL be accepted on an edge where rx_cor_valid=1 and tx_cor_ready=1; the inputs are sampled only at that edge.
REQ-018 The FSM SHALL have the states IDLE, DISC, FILT and UPDATE, with the transitions IDLE->DISC on acceptance, DISC->FILT, FILT->UPDATE and UPDATE->IDLE unconditionally.
REQ-019 tx_cor_ready SHALL be 1 only in IDLE, giving a throughput of one pair per 4 cycles.
REQ-020 In DISC the block SHALL register err = Q when I>=0 and err = -Q when I<0, as a signed value of COR_WIDTH+1 bits (so -(-2^(COR_WIDTH-1)) is exact).
REQ-021 In FILT: integ <= integ + (err sign-extended to ACC_WIDTH, <<< KI_SHIFT), signed, saturating at the signed ACC_WIDTH max/min; when rx_loop_en=0, integ <= 0 instead.
REQ-022 In UPDATE: tx_car_fcw <= FCW_INIT + integ + (err <<< KP_SHIFT), modulo 2^ACC_WIDTH (wraps, no saturation); when rx_loop_en=0, tx_car_fcw <= FCW_INIT.
REQ-023 tx_fcw_valid SHALL be 1 for exactly the cycle following the UPDATE edge, i.e. the result is visible 3 edges after the acceptance edge.
REQ-024 The lock counter SHALL update in DISC: if |I|>|Q| it increments, saturating at LOCK_CNT; otherwise it clears to 0.
REQ-025 tx_lock SHALL be 1 while the lock counter equals LOCK_CNT, and SHALL go to 0 on the first failing sample.
REQ-026 rx_loop_en SHALL be sampled in FILT and UPDATE only; changing it mid-sequence affects only the stages not yet executed.
REQ-027 rx_cor_valid held high while tx_cor_ready=0 SHALL NOT cause a second acceptance; the source must hold its data.

Reset
REQ-028 Asserting rx_rst_n=0, at any time including mid-sequence, SHALL force state IDLE, integ=0, err=0, lock counter=0, tx_car_fcw=FCW_INIT, tx_fcw_valid=0, tx_lock=0, and tx_cor_ready=1 after release; any in-flight pair is discarded.

Structure
REQ-029 The state encoding and the default parameter constants (ACC_WIDTH, COR_WIDTH, FCW_INIT) SHALL reside in the shared carrier package used by the carrier generator.
REQ-030 The lock detector (REQ-024/025) SHALL be a separate sub-module, car_lock_det; the discriminator and filter SHALL stay in car_loop.

Verification (defaults, rx_loop_en=1 unless stated)
REQ-031 Reset -> tx_car_fcw=32'h1000_0000, tx_cor_ready=1, tx_fcw_valid=0, tx_lock=0.
REQ-032 I=100, Q=10 accepted at edge E0 -> at E3 tx_car_fcw=32'h1000_0A28 with tx_fcw_valid pulsed for one cycle; tx_cor_ready=0 during E0..E3.
REQ-033 From reset, I=-100, Q=10 -> tx_car_fcw=32'h0FFF_F5D8; then I=-100, Q=-10 -> integ returns to 0 and tx_car_fcw=32'h1000_0A00.
REQ-034 Four pairs with I=1000, Q=5 -> tx_lock=1 after the 4th DISC; a fifth pair with I=5, Q=1000 -> tx_lock=0.
REQ-035 With KI_SHIFT=30, repeated pairs I=1, Q=32767 -> integ saturates at 32'h7FFF_FFFF and does not wrap; tx_car_fcw wraps modulo 2^32.
REQ-036 rx_rst_n pulsed low in FILT -> no tx_fcw_valid pulse, all outputs at reset values, and the next pair is processed normally; rx_loop_en=0 -> tx_car_fcw=FCW_INIT and integ=0.

Source files
------------

// File: rtl/car_loop_pkg.sv
// Shared carrier package: sequencing states and default carrier constants
// used by the carrier loop and the carrier generator.
package car_loop_pkg;

   localparam int          ACC_WIDTH_DEF = 32;
   localparam int          COR_WIDTH_DEF = 16;
   localparam logic [31:0] FCW_INIT_DEF  = 32'h1000_0000;

   // One pair is walked through these four steps; IDLE is the only
   // step in which a new pair can be taken.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DISC   = 2'd1,
      FILT   = 2'd2,
      UPDATE = 2'd3
   } car_state_e;

endpackage

// File: rtl/car_lock_det.sv
// Carrier lock detector: counts consecutive samples whose in-phase
// magnitude dominates the quadrature magnitude.
module car_lock_det #(
   parameter int COR_WIDTH = 16,
   parameter int LOCK_CNT  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        sample,
   input  logic signed [COR_WIDTH-1:0] cor_i,
   input  logic signed [COR_WIDTH-1:0] cor_q,
   output logic                        lock
);

   localparam int CNT_W = $clog2(LOCK_CNT + 1);

   // One extra bit so the magnitude of the most negative value is exact.
   logic signed [COR_WIDTH:0] i_ext, q_ext;
   logic        [COR_WIDTH:0] abs_i, abs_q;
   logic        [CNT_W-1:0]   count;

   // Magnitudes of the held correlation pair.
   always_comb begin
      i_ext = {cor_i[COR_WIDTH-1], cor_i};
      q_ext = {cor_q[COR_WIDTH-1], cor_q};
      abs_i = i_ext[COR_WIDTH] ? -i_ext : i_ext;
      abs_q = q_ext[COR_WIDTH] ? -q_ext : q_ext;
   end

   // Saturating run counter; any non-dominant sample restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (sample) begin
         if (abs_i > abs_q) begin
            if (count != CNT_W'(LOCK_CNT)) begin
               count <= count + 1'b1;
            end
         end else begin
            count <= '0;
         end
      end
   end

   assign lock = (count == CNT_W'(LOCK_CNT));

endmodule

// File: rtl/car_loop.sv
// Carrier tracking loop: Costas-style discriminator feeding a
// proportional-integral filter that steers the carrier NCO word.
// Handshake: a pair is taken on a rising edge where rx_cor_valid and
// tx_cor_ready are both 1; the source holds its data while ready is 0.
module car_loop
   import car_loop_pkg::*;
#(
   parameter int                   ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int                   COR_WIDTH = COR_WIDTH_DEF,
   parameter logic [ACC_WIDTH-1:0] FCW_INIT  = FCW_INIT_DEF,
   parameter int                   KP_SHIFT  = 8,
   parameter int                   KI_SHIFT  = 2,
   parameter int                   LOCK_CNT  = 4
) (
   input  logic                        rx_clk,
   input  logic                        rx_rst_n,
   input  logic                        rx_loop_en,
   input  logic                        rx_cor_valid,
   input  logic signed [COR_WIDTH-1:0] rx_cor_i,
   input  logic signed [COR_WIDTH-1:0] rx_cor_q,
   output logic                        tx_cor_ready,
   output logic        [ACC_WIDTH-1:0] tx_car_fcw,
   output logic                        tx_fcw_valid,
   output logic                        tx_lock
);

   // Wide enough that the shifted error plus the integrator never wraps
   // before the saturation check.
   localparam int SUM_W = ACC_WIDTH + COR_WIDTH + KI_SHIFT + 2;
   localparam logic signed [SUM_W-1:0] SAT_MAX =
      {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_MIN =
      {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

   car_state_e                  state, state_nxt;
   logic                        accept;
   logic                        disc_stb;
   logic signed [COR_WIDTH-1:0] cor_i, cor_q;
   logic signed [COR_WIDTH:0]   q_ext;
   logic signed [COR_WIDTH:0]   err, err_nxt;
   logic signed [ACC_WIDTH-1:0] integ, integ_nxt;
   logic signed [SUM_W-1:0]     integ_ext, err_ext, sum_wide;
   logic        [ACC_WIDTH-1:0] err_acc, kp_term, fcw_nxt;

   assign accept   = rx_cor_valid & tx_cor_ready;
   assign disc_stb = (state == DISC);

   // Sequencing register.
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next step and ready: only IDLE waits for input, the rest advance.
   always_comb begin
      state_nxt    = state;
      tx_cor_ready = 1'b0;
      case (state)
         IDLE: begin
            tx_cor_ready = 1'b1;
            if (rx_cor_valid) begin
               state_nxt = DISC;
            end
         end
         DISC:    state_nxt = FILT;
         FILT:    state_nxt = UPDATE;
         UPDATE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Discriminator: flip Q by the sign of I so the error is phase-sign aware.
   always_comb begin
      q_ext   = {cor_q[COR_WIDTH-1], cor_q};
      err_nxt = cor_i[COR_WIDTH-1] ? -q_ext : q_ext;
   end

   // Integrator update with saturation at the signed accumulator limits.
   always_comb begin
      integ_ext = {{(SUM_W-ACC_WIDTH){integ[ACC_WIDTH-1]}}, integ};
      err_ext   = {{(SUM_W-COR_WIDTH-1){err[COR_WIDTH]}}, err};
      sum_wide  = integ_ext + (err_ext <<< KI_SHIFT);
      if (sum_wide > SAT_MAX) begin
         integ_nxt = SAT_MAX[ACC_WIDTH-1:0];
      end else if (sum_wide < SAT_MIN) begin
         integ_nxt = SAT_MIN[ACC_WIDTH-1:0];
      end else begin
         integ_nxt = sum_wide[ACC_WIDTH-1:0];
      end
   end

   // NCO word: nominal plus integral plus proportional, wrapping freely.
   always_comb begin
      err_acc = {{(ACC_WIDTH-COR_WIDTH-1){err[COR_WIDTH]}}, err};
      kp_term = err_acc << KP_SHIFT;
      fcw_nxt = FCW_INIT + integ + kp_term;
   end

   // Datapath registers, each loaded in its own step.
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         cor_i        <= '0;
         cor_q        <= '0;
         err          <= '0;
         integ        <= '0;
         tx_car_fcw   <= FCW_INIT;
         tx_fcw_valid <= 1'b0;
      end else begin
         tx_fcw_valid <= (state == UPDATE);
         if (accept) begin
            cor_i <= rx_cor_i;
            cor_q <= rx_cor_q;
         end
         if (state == DISC) begin
            err <= err_nxt;
         end
         if (state == FILT) begin
            integ <= rx_loop_en ? integ_nxt : '0;
         end
         if (state == UPDATE) begin
            tx_car_fcw <= rx_loop_en ? fcw_nxt : FCW_INIT;
         end
      end
   end

   car_lock_det #(
      .COR_WIDTH (COR_WIDTH),
      .LOCK_CNT  (LOCK_CNT)
   ) u_lock_det (
      .clk    (rx_clk),
      .rst_n  (rx_rst_n),
      .sample (disc_stb),
      .cor_i  (cor_i),
      .cor_q  (cor_q),
      .lock   (tx_lock)
   );

endmodule

// File: tb/tb_car_loop.sv
// Bench for car_loop: one instance with default gains and one with a
// large integral gain, both fed the same pairs and compared every cycle
// against a transaction-level model, plus literal spot values.
module tb_car_loop;

   localparam logic [31:0] INIT = 32'h1000_0000;

   logic               rx_clk;
   logic               rx_rst_n;
   logic               rx_loop_en;
   logic               rx_cor_valid;
   logic signed [15:0] rx_cor_i;
   logic signed [15:0] rx_cor_q;

   logic        rdy0, val0, lock0;
   logic [31:0] fcw0;
   logic        rdy1, val1, lock1;
   logic [31:0] fcw1;

   int n_checks = 0;
   int n_pass   = 0;

   car_loop dut (
      .rx_clk       (rx_clk),
      .rx_rst_n     (rx_rst_n),
      .rx_loop_en   (rx_loop_en),
      .rx_cor_valid (rx_cor_valid),
      .rx_cor_i     (rx_cor_i),
      .rx_cor_q     (rx_cor_q),
      .tx_cor_ready (rdy0),
      .tx_car_fcw   (fcw0),
      .tx_fcw_valid (val0),
      .tx_lock      (lock0)
   );

   car_loop #(.KI_SHIFT(30)) dut_sat (
      .rx_clk       (rx_clk),
      .rx_rst_n     (rx_rst_n),
      .rx_loop_en   (rx_loop_en),
      .rx_cor_valid (rx_cor_valid),
      .rx_cor_i     (rx_cor_i),
      .rx_cor_q     (rx_cor_q),
      .tx_cor_ready (rdy1),
      .tx_car_fcw   (fcw1),
      .tx_fcw_valid (val1),
      .tx_lock      (lock1)
   );

   // Clock.
   initial begin
      rx_clk = 1'b0;
      forever #5 rx_clk = ~rx_clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) return 64'sd2147483647;
      if (v < -64'sd2147483648) return -64'sd2147483648;
      return v;
   endfunction

   // Reference model: one pair in flight, age counts edges since it was taken.
   int          m_age      = 0;
   int          m_i        = 0;
   int          m_q        = 0;
   int          m_err      = 0;
   int          m_lock_cnt = 0;
   longint      m_integ[2] = '{0, 0};
   logic [31:0] m_fcw[2]   = '{INIT, INIT};
   logic        m_valid    = 1'b0;
   logic        m_acc      = 1'b0;
   int          ki[2]      = '{2, 30};

   always @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         m_age = 0; m_err = 0; m_lock_cnt = 0; m_valid = 1'b0; m_acc = 1'b0;
         for (int k = 0; k < 2; k++) begin
            m_integ[k] = 0;
            m_fcw[k]   = INIT;
         end
      end else begin
         m_valid = 1'b0;
         m_acc   = 1'b0;
         case (m_age)
            0: if (rx_cor_valid) begin
                  m_i = rx_cor_i; m_q = rx_cor_q; m_acc = 1'b1; m_age = 1;
               end
            1: begin
                  m_err = (m_i >= 0) ? m_q : -m_q;
                  if (iabs(m_i) > iabs(m_q)) m_lock_cnt = (m_lock_cnt < 4) ? m_lock_cnt + 1 : 4;
                  else m_lock_cnt = 0;
                  m_age = 2;
               end
            2: begin
                  for (int k = 0; k < 2; k++)
                     m_integ[k] = rx_loop_en ? sat32(m_integ[k] + longint'(m_err) * (64'sd1 <<< ki[k])) : 0;
                  m_age = 3;
               end
            default: begin
                  for (int k = 0; k < 2; k++)
                     m_fcw[k] = rx_loop_en ? 32'(longint'(INIT) + m_integ[k] + longint'(m_err) * 256) : INIT;
                  m_valid = 1'b1;
                  m_age   = 0;
               end
         endcase
      end
   end

   // Cycle-by-cycle comparison of both instances against the model.
   always @(posedge rx_clk) begin
      #1;
      check("fcw_ki2",    fcw0,  m_fcw[0]);
      check("fcw_ki30",   fcw1,  m_fcw[1]);
      check("valid_ki2",  32'(val0),  32'(m_valid));
      check("valid_ki30", 32'(val1),  32'(m_valid));
      check("ready_ki2",  32'(rdy0),  32'(m_age == 0));
      check("ready_ki30", 32'(rdy1),  32'(m_age == 0));
      check("lock_ki2",   32'(lock0), 32'(m_lock_cnt == 4));
      check("lock_ki30",  32'(lock1), 32'(m_lock_cnt == 4));
   end

   // Driver tasks.
   task automatic do_reset();
      @(negedge rx_clk);
      rx_rst_n = 1'b0;
      @(negedge rx_clk);
      rx_rst_n = 1'b1;
   endtask

   task automatic send_pair(input int i, input int q);
      int waited = 0;
      @(negedge rx_clk);
      rx_cor_i     = 16'(i);
      rx_cor_q     = 16'(q);
      rx_cor_valid = 1'b1;
      while (!rdy0 && waited < 10) begin
         @(negedge rx_clk);
         waited++;
      end
      check("accept_wait", 32'(rdy0), 32'd1);
      @(negedge rx_clk);
      rx_cor_valid = 1'b0;
   endtask

   task automatic run_pair(input int i, input int q);
      send_pair(i, q);
      repeat (3) @(negedge rx_clk);
   endtask

   // Directed cases with literal values, then randomized traffic.
   initial begin
      rx_rst_n     = 1'b0;
      rx_loop_en   = 1'b1;
      rx_cor_valid = 1'b0;
      rx_cor_i     = '0;
      rx_cor_q     = '0;
      repeat (2) @(negedge rx_clk);
      rx_rst_n = 1'b1;
      check("reset_fcw",   fcw0, INIT);
      check("reset_ready", 32'(rdy0), 32'd1);
      check("reset_valid", 32'(val0), 32'd0);
      check("reset_lock",  32'(lock0), 32'd0);

      // Basic pair, latency and one-cycle pulse.
      send_pair(100, 10);
      check("busy_ready", 32'(rdy0), 32'd0);
      repeat (3) @(negedge rx_clk);
      check("basic_fcw",   fcw0, 32'h1000_0A28);
      check("basic_valid", 32'(val0), 32'd1);
      @(negedge rx_clk);
      check("basic_pulse_end", 32'(val0), 32'd0);

      // Negative I flips the error sign; integrator returns to zero.
      do_reset();
      run_pair(-100, 10);
      check("neg_i_fcw", fcw0, 32'h0FFF_F5D8);
      run_pair(-100, -10);
      check("neg_i_back_fcw", fcw0, 32'h1000_0A00);

      // Lock run.
      do_reset();
      repeat (3) run_pair(1000, 5);
      check("lock_after3", 32'(lock0), 32'd0);
      run_pair(1000, 5);
      check("lock_after4", 32'(lock0), 32'd1);
      run_pair(5, 1000);
      check("lock_lost", 32'(lock0), 32'd0);

      // Integrator saturation on the large-gain instance.
      do_reset();
      run_pair(1, 32767);
      check("sat_fcw_ki2",  fcw0, 32'h1081_FEFC);
      check("sat_fcw_ki30", fcw1, 32'h907F_FEFF);
      run_pair(1, 32767);
      check("sat_hold_ki30", fcw1, 32'h907F_FEFF);
      run_pair(-1, 32767);
      check("sat_min_ki30", fcw1, 32'h8F80_0100);

      // Reset while in the filter step discards the pair.
      do_reset();
      send_pair(100, 10);
      @(negedge rx_clk);
      rx_rst_n = 1'b0;
      @(negedge rx_clk);
      rx_rst_n = 1'b1;
      repeat (3) begin
         @(negedge rx_clk);
         check("midrst_valid", 32'(val0), 32'd0);
         check("midrst_fcw",   fcw0, INIT);
      end
      check("midrst_ready", 32'(rdy0), 32'd1);
      run_pair(100, 10);
      check("after_midrst_fcw", fcw0, 32'h1000_0A28);

      // Loop disabled: nominal word, integrator cleared.
      rx_loop_en = 1'b0;
      run_pair(100, 10);
      check("disabled_fcw", fcw0, INIT);
      rx_loop_en = 1'b1;
      run_pair(100, 10);
      check("reenabled_fcw", fcw0, 32'h1000_0A28);

      // Randomized traffic; the source holds a pending pair until taken.
      for (int c = 0; c < 4000; c++) begin
         @(negedge rx_clk);
         if (!rx_rst_n) rx_rst_n = 1'b1;
         else if ($urandom_range(0, 299) == 0) rx_rst_n = 1'b0;
         if ((c % 20) == 0) rx_loop_en = ($urandom_range(0, 7) != 0);
         if (!rx_cor_valid || m_acc) begin
            rx_cor_valid = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
               0: begin rx_cor_i = 16'($urandom); rx_cor_q = 16'($urandom); end
               1: begin
                     rx_cor_i = 16'($urandom_range(1000, 30000));
                     if ($urandom_range(0, 1) == 1) rx_cor_i = -rx_cor_i;
                     rx_cor_q = 16'(int'($urandom_range(0, 100)) - 50);
                  end
               2: begin
                     rx_cor_i = ($urandom_range(0, 1) == 1) ? 16'sh8000 : 16'sh7FFF;
                     rx_cor_q = ($urandom_range(0, 1) == 1) ? 16'sh8000 : 16'sh7FFF;
                  end
               default: begin
                     rx_cor_i = 16'(int'($urandom_range(0, 20)) - 10);
                     rx_cor_q = 16'(int'($urandom_range(0, 20)) - 10);
                  end
            endcase
         end
      end
      rx_rst_n     = 1'b1;
      rx_cor_valid = 1'b0;
      repeat (6) @(negedge rx_clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
